// File: rtl/bakraid_pkg.sv
// Shared types and constants for the Bakraid PCM prefetch slice.
package bakraid_pkg;

    localparam int unsigned PCM_AW = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } pf_state_e;

endpackage

// File: rtl/bakraid_byte_ring.sv
// DEPTH x 8 byte ring with push/pop/clear; clear wins over push and pop.
module bakraid_byte_ring #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [7:0]                 push_data_i,
    input  logic                       pop_i,
    output logic [7:0]                 head_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH):0]     count_next_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + 1'b1;
            if (pop_i)  rd_d = rd_q + 1'b1;
            if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
            else if (pop_i && !push_i) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_q] <= push_data_i;
    end

    assign head_data_o  = mem_q[rd_q];
    assign count_o      = cnt_q;
    assign count_next_o = cnt_d;

endmodule

// File: rtl/bakraid_pcm_prefetch.sv
// Sequential-read PCM byte prefetch between a YMZ280B channel and an SDRAM slot.
// Optional hit/miss counters: define BAKRAID_PCM_PREFETCH_STATS_EN.
module bakraid_pcm_prefetch
    import bakraid_pkg::*;
#(
    parameter int unsigned AW    = PCM_AW,
    parameter int unsigned DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          REQ,
    input  logic [AW-1:0] REQ_ADDR,
    input  logic          FLUSH,
    output logic          REQ_BUSY,
    output logic          REQ_VALID,
    output logic [7:0]    REQ_DATA,
    output logic          SLOT_CS,
    output logic [AW-1:0] SLOT_ADDR,
    input  logic          SLOT_OK,
    input  logic [7:0]    SLOT_DOUT
`ifdef BAKRAID_PCM_PREFETCH_STATS_EN
    ,
    output logic [15:0]   HIT_CNT,
    output logic [15:0]   MISS_CNT
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    pf_state_e     state_q, state_d;
    logic [AW-1:0] head_q, head_d, fetch_q, fetch_d;
    logic          primed_q, primed_d, busy_q, busy_d, valid_q, valid_d;
    logic [7:0]    data_q, data_d;

    logic [CW-1:0] count, count_next;
    logic [7:0]    ring_head;
    logic          req_acc, hit, miss, fill;

    // FLUSH reopens the request path so a simultaneous REQ lands as a fresh miss.
    assign req_acc = REQ && (!busy_q || FLUSH);
    assign hit     = req_acc && !FLUSH && (count != '0) && (REQ_ADDR == head_q);
    assign miss    = req_acc && !hit;
    assign fill    = (state_q == ST_WAIT) && SLOT_OK && !FLUSH && !miss;

    bakraid_byte_ring #(
        .DEPTH(DEPTH)
    ) u_ring (
        .clk_i        (CLK),
        .rst_ni       (RESETn),
        .clear_i      (FLUSH || miss),
        .push_i       (fill && !busy_q),
        .push_data_i  (SLOT_DOUT),
        .pop_i        (hit),
        .head_data_o  (ring_head),
        .count_o      (count),
        .count_next_o (count_next)
    );

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        fetch_d  = fetch_q;
        primed_d = primed_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        data_d   = data_q;

        if (FLUSH) begin
            primed_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
        end

        if (miss) begin
            head_d   = REQ_ADDR;
            fetch_d  = REQ_ADDR;
            primed_d = 1'b1;
            busy_d   = 1'b1;
            state_d  = ST_ADDR;
        end else if (!FLUSH) begin
            if (hit) begin
                valid_d = 1'b1;
                data_d  = ring_head;
                head_d  = head_q + 1'b1;
            end
            unique case (state_q)
                ST_IDLE: if (primed_q && count < CW'(DEPTH)) state_d = ST_ADDR;
                ST_ADDR: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (fill) begin
                        fetch_d = fetch_q + 1'b1;
                        // The byte owed to a pending miss is handed out directly, never queued.
                        if (busy_q) begin
                            valid_d = 1'b1;
                            data_d  = SLOT_DOUT;
                            head_d  = head_q + 1'b1;
                            busy_d  = 1'b0;
                        end
                        state_d = (count_next < CW'(DEPTH)) ? ST_ADDR : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= ST_IDLE;
            head_q   <= '0;
            fetch_q  <= '0;
            primed_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            fetch_q  <= fetch_d;
            primed_q <= primed_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign REQ_BUSY  = busy_q;
    assign REQ_VALID = valid_q;
    assign REQ_DATA  = data_q;
    assign SLOT_CS   = (state_q != ST_IDLE);
    assign SLOT_ADDR = fetch_q;

`ifdef BAKRAID_PCM_PREFETCH_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 16'd1;
            if (miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign HIT_CNT  = hit_cnt_q;
    assign MISS_CNT = miss_cnt_q;
`endif

endmodule
